result_collect: RTL and testbench

- Drains the systolic array output edge and is the inverse of the weight feeder.
- Accepts one byte per lane per enabled cycle on four lanes (A–D) and packs four consecutive bytes per lane into a 32-bit word.
- Buffers completed word groups in a small FIFO and presents them to the readout/bus side with a valid/ready handshake.

---
 rtl/result_collect_pkg.sv | 16 +
 rtl/result_collect_if.sv | 31 +++
 rtl/result_collect_rc_fifo.sv | 70 +++++++
 rtl/result_collect.sv | 95 +++++++++
 tb/tb_result_collect.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/result_collect_pkg.sv
// Shared types for the result collector: lane widths, lane index and the packed
// 4-lane word group that forms one FIFO entry.
package result_collect_pkg;

    localparam int unsigned DW    = 8;
    localparam int unsigned BYTES = 4;
    localparam int unsigned WW    = DW * BYTES;
    localparam int unsigned LANES = 4;
    localparam int unsigned BCW   = $clog2(BYTES);

    typedef enum logic [1:0] {LaneA, LaneB, LaneC, LaneD} lane_e;

    typedef logic [BYTES-1:0][DW-1:0] word_t;
    typedef word_t [LANES-1:0]        word_grp_t;

endpackage

// File: rtl/result_collect_if.sv
// Lane-byte input side and packed-word readout side of the result collector.
interface result_collect_if;
    import result_collect_pkg::*;

    logic          en_in;
    logic          clr;
    logic [DW-1:0] dinA;
    logic [DW-1:0] dinB;
    logic [DW-1:0] dinC;
    logic [DW-1:0] dinD;
    logic          in_ready;
    logic [BCW-1:0] byte_cnt;
    logic          out_valid;
    logic          out_ready;
    logic [WW-1:0] doutA;
    logic [WW-1:0] doutB;
    logic [WW-1:0] doutC;
    logic [WW-1:0] doutD;
    logic          overflow;

    modport master (
        output en_in, clr, dinA, dinB, dinC, dinD, out_ready,
        input  in_ready, byte_cnt, out_valid, doutA, doutB, doutC, doutD, overflow
    );

    modport slave (
        input  en_in, clr, dinA, dinB, dinC, dinD, out_ready,
        output in_ready, byte_cnt, out_valid, doutA, doutB, doutC, doutD, overflow
    );

endinterface

// File: rtl/result_collect_rc_fifo.sv
// Synchronous FIFO with a registered head; the head keeps the last popped entry
// while the FIFO is empty.
module rc_fifo #(
    parameter  int unsigned Width = 128,
    parameter  int unsigned Depth = 2,
    localparam int unsigned PtrW  = $clog2(Depth),
    localparam int unsigned CntW  = $clog2(Depth) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count,
    output logic [Width-1:0] head
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [Width-1:0] head_q, head_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
        head_d   = head_q;
        // The slot the next head comes from may be the one being written this edge.
        if (count_d != '0) begin
            head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? din : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
            end
        end
    end

    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/result_collect.sv
// Packs four consecutive lane bytes LSB-first into 32-bit words on four lanes and
// queues completed word groups for a valid/ready readout.
module result_collect
    import result_collect_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input logic              clk,
    input logic              rst,
    result_collect_if.slave  bus
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    word_grp_t                  asm_q, asm_d, merged, head;
    logic [LANES-1:0][DW-1:0]   lane_din;
    logic [BCW-1:0]             byte_cnt_q, byte_cnt_d;
    logic                       overflow_q, overflow_d;
    logic                       accept, push, pop, full, empty;
    logic [CntW-1:0]            fifo_count;
    logic [$bits(word_grp_t)-1:0] head_raw;

    assign lane_din = {bus.dinD, bus.dinC, bus.dinB, bus.dinA};

    // full is purely registered, so a same-cycle pop never rescues a beat.
    assign accept = bus.en_in && !full && !bus.clr;
    assign push   = accept && (byte_cnt_q == BCW'(BYTES - 1));
    assign pop    = !empty && bus.out_ready;

    always_comb begin
        merged = asm_q;
        for (int l = 0; l < int'(LANES); l++) begin
            merged[l][byte_cnt_q] = lane_din[l];
        end
    end

    always_comb begin
        asm_d      = asm_q;
        byte_cnt_d = byte_cnt_q;
        overflow_d = overflow_q | (bus.en_in && full && !bus.clr);
        if (bus.clr) begin
            asm_d      = '0;
            byte_cnt_d = '0;
        end else if (accept) begin
            if (push) begin
                asm_d      = '0;
                byte_cnt_d = '0;
            end else begin
                asm_d      = merged;
                byte_cnt_d = byte_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q      <= '0;
            byte_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            asm_q      <= asm_d;
            byte_cnt_q <= byte_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    rc_fifo #(
        .Width ($bits(word_grp_t)),
        .Depth (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (merged),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .count (fifo_count),
        .head  (head_raw)
    );

    assign head = head_raw;

    assert property (@(posedge clk) disable iff (rst) fifo_count <= CntW'(DEPTH));

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.byte_cnt  = byte_cnt_q;
    assign bus.overflow  = overflow_q;
    assign bus.doutA     = head[LaneA];
    assign bus.doutB     = head[LaneB];
    assign bus.doutC     = head[LaneC];
    assign bus.doutD     = head[LaneD];

endmodule

// File: tb/tb_result_collect.sv
// Bench for result_collect: directed scenarios plus a randomized run, all checked
// against a queue-based model of lane packing and the word FIFO.
module tb_result_collect;
    import result_collect_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst;

    result_collect_if bus ();

    result_collect #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: partial words per lane, queued groups (lane l at bits [32l+31:32l]).
    logic [127:0] m_q [$];
    logic [31:0]  m_part [4];
    int           m_cnt;
    bit           m_ovf;
    logic [127:0] m_last;

    function automatic void model_reset();
        m_q.delete();
        for (int l = 0; l < 4; l++) m_part[l] = '0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_last = '0;
    endfunction

    function automatic void model_step(input bit en, input bit c, input logic [31:0] d4,
                                       input bit ordy);
        bit           ready;
        bit           do_pop;
        bit           do_push;
        logic [127:0] grp;
        ready   = (m_q.size() != int'(DEPTH));
        do_pop  = (m_q.size() != 0) && ordy;
        do_push = 1'b0;
        grp     = '0;
        if (c) begin
            m_cnt = 0;
            for (int l = 0; l < 4; l++) m_part[l] = '0;
        end else if (en && ready) begin
            for (int l = 0; l < 4; l++) begin
                m_part[l] = m_part[l] | (32'((d4 >> (8 * l)) & 32'hff) << (8 * m_cnt));
            end
            if (m_cnt == 3) begin
                for (int l = 0; l < 4; l++) grp = grp | (128'(m_part[l]) << (32 * l));
                do_push = 1'b1;
                m_cnt   = 0;
                for (int l = 0; l < 4; l++) m_part[l] = '0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else if (en) begin
            m_ovf = 1'b1;
        end
        if (do_pop) m_last = m_q.pop_front();
        if (do_push) m_q.push_back(grp);
    endfunction

    // {out_valid, in_ready, byte_cnt, overflow}
    function automatic logic [4:0] exp_status();
        logic [1:0] cnt;
        cnt = m_cnt[1:0];
        return {m_q.size() != 0, m_q.size() != int'(DEPTH), cnt, m_ovf};
    endfunction

    function automatic logic [127:0] exp_dout();
        return (m_q.size() != 0) ? m_q[0] : m_last;
    endfunction

    function automatic logic [31:0] lane_bytes(input logic [7:0] a);
        return {a + 8'h30, a + 8'h20, a + 8'h10, a};
    endfunction

    task automatic cycle(input bit en, input bit c, input logic [31:0] d4, input bit ordy);
        bus.en_in     = en;
        bus.clr       = c;
        bus.dinA      = d4[7:0];
        bus.dinB      = d4[15:8];
        bus.dinC      = d4[23:16];
        bus.dinD      = d4[31:24];
        bus.out_ready = ordy;
        model_step(en, c, d4, ordy);
        @(posedge clk);
        #1;
        bus.en_in = 1'b0;
        bus.clr   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [4:0]   st;
        logic [127:0] dv;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        st = {bus.out_valid, bus.in_ready, bus.byte_cnt, bus.overflow};
        n_checks++;
        if (st !== 5'b01000) $display("FAIL reset_status act=%b exp=%b", st, 5'b01000);
        else n_pass++;
        dv = {bus.doutD, bus.doutC, bus.doutB, bus.doutA};
        n_checks++;
        if (dv !== 128'h0) $display("FAIL reset_dout act=%h exp=0", dv);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic_pack();
        logic [127:0] dv;
        do_reset();
        for (int k = 1; k <= 4; k++) cycle(1'b1, 1'b0, lane_bytes(8'(k)), 1'b1);
        dv = {bus.doutD, bus.doutC, bus.doutB, bus.doutA};
        n_checks++;
        if (bus.out_valid !== 1'b1 || dv !== 128'h34333231_24232221_14131211_04030201)
            $display("FAIL basic_word act=%b/%h exp=1/34333231242322211413121104030201",
                     bus.out_valid, dv);
        else n_pass++;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL basic_one_cycle act=%b exp=0", bus.out_valid);
        else n_pass++;
        n_checks++;
        if ({bus.out_valid, bus.in_ready, bus.byte_cnt, bus.overflow} !== exp_status())
            $display("FAIL basic_status act=%b exp=%b",
                     {bus.out_valid, bus.in_ready, bus.byte_cnt, bus.overflow}, exp_status());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 1; k <= 8; k++) cycle(1'b1, 1'b0, lane_bytes(8'(k)), 1'b0);
        n_checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL full_in_ready act=%b exp=0", bus.in_ready);
        else n_pass++;
        cycle(1'b1, 1'b0, lane_bytes(8'd9), 1'b0);
        n_checks++;
        if ({bus.overflow, bus.byte_cnt} !== 3'b100)
            $display("FAIL full_overflow act=%b exp=100", {bus.overflow, bus.byte_cnt});
        else n_pass++;
        n_checks++;
        if (bus.doutA !== 32'h04030201) $display("FAIL full_head0 act=%h exp=04030201", bus.doutA);
        else n_pass++;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.doutA !== 32'h08070605 || bus.doutD !== 32'h38373635)
            $display("FAIL full_head1 act=%b/%h/%h exp=1/08070605/38373635",
                     bus.out_valid, bus.doutA, bus.doutD);
        else n_pass++;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.doutA !== 32'h08070605 || bus.overflow !== 1'b1)
            $display("FAIL full_drained act=%b/%h/%b exp=0/08070605/1",
                     bus.out_valid, bus.doutA, bus.overflow);
        else n_pass++;
    endtask

    task automatic test_simul_push_pop();
        logic [127:0] dv;
        do_reset();
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, $urandom, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, $urandom, 1'b0);
        cycle(1'b1, 1'b0, $urandom, 1'b1);
        n_checks++;
        if ({bus.out_valid, bus.in_ready, bus.byte_cnt, bus.overflow} !== 5'b11000)
            $display("FAIL simul_status act=%b exp=11000",
                     {bus.out_valid, bus.in_ready, bus.byte_cnt, bus.overflow});
        else n_pass++;
        dv = {bus.doutD, bus.doutC, bus.doutB, bus.doutA};
        n_checks++;
        if (dv !== exp_dout()) $display("FAIL simul_head act=%h exp=%h", dv, exp_dout());
        else n_pass++;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b0 || {bus.doutD, bus.doutC, bus.doutB, bus.doutA} !== dv)
            $display("FAIL simul_no_dup act=%b/%h exp=0/%h", bus.out_valid,
                     {bus.doutD, bus.doutC, bus.doutB, bus.doutA}, dv);
        else n_pass++;
    endtask

    task automatic test_clr();
        do_reset();
        cycle(1'b1, 1'b0, {$urandom_range(0, 16777215)} << 8 | 32'hAA, 1'b0);
        cycle(1'b1, 1'b0, {$urandom_range(0, 16777215)} << 8 | 32'hBB, 1'b0);
        cycle(1'b1, 1'b1, 32'h000000CC, 1'b0);
        n_checks++;
        if ({bus.byte_cnt, bus.overflow, bus.out_valid} !== 4'b0000)
            $display("FAIL clr_state act=%b exp=0000",
                     {bus.byte_cnt, bus.overflow, bus.out_valid});
        else n_pass++;
        cycle(1'b1, 1'b0, 32'h11, 1'b0);
        cycle(1'b1, 1'b0, 32'h22, 1'b0);
        cycle(1'b1, 1'b0, 32'h33, 1'b0);
        cycle(1'b1, 1'b0, 32'h44, 1'b0);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.doutA !== 32'h44332211)
            $display("FAIL clr_word act=%b/%h exp=1/44332211", bus.out_valid, bus.doutA);
        else n_pass++;
    endtask

    task automatic test_gapped();
        logic [31:0]  beats [4];
        logic [127:0] want;
        logic [127:0] dv;
        do_reset();
        want = '0;
        for (int k = 0; k < 4; k++) begin
            beats[k] = $urandom;
            for (int l = 0; l < 4; l++) want[32 * l + 8 * k +: 8] = beats[k][8 * l +: 8];
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b0, beats[k], 1'b0);
            for (int g = 0; g < 1 + int'($urandom_range(0, 2)); g++) begin
                cycle(1'b0, 1'b0, $urandom, 1'b0);
                n_checks++;
                if (bus.byte_cnt !== 2'((k + 1) % 4))
                    $display("FAIL gap_hold act=%0d exp=%0d", bus.byte_cnt, (k + 1) % 4);
                else n_pass++;
            end
        end
        dv = {bus.doutD, bus.doutC, bus.doutB, bus.doutA};
        n_checks++;
        if (bus.out_valid !== 1'b1 || dv !== want)
            $display("FAIL gap_word act=%b/%h exp=1/%h", bus.out_valid, dv, want);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [127:0] dv;
        do_reset();
        for (int k = 0; k < 7; k++) cycle(1'b1, 1'b0, $urandom, 1'b0);
        rst = 1'b1;
        #2;
        n_checks++;
        if ({bus.out_valid, bus.in_ready, bus.byte_cnt, bus.overflow} !== 5'b01000)
            $display("FAIL arst_status act=%b exp=01000",
                     {bus.out_valid, bus.in_ready, bus.byte_cnt, bus.overflow});
        else n_pass++;
        dv = {bus.doutD, bus.doutC, bus.doutB, bus.doutA};
        n_checks++;
        if (dv !== 128'h0) $display("FAIL arst_dout act=%h exp=0", dv);
        else n_pass++;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, $urandom, 1'b0);
        dv = {bus.doutD, bus.doutC, bus.doutB, bus.doutA};
        n_checks++;
        if (bus.out_valid !== 1'b1 || dv !== exp_dout())
            $display("FAIL arst_repack act=%b/%h exp=1/%h", bus.out_valid, dv, exp_dout());
        else n_pass++;
    endtask

    task automatic test_random();
        bit en, c, ordy;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 9) < 7);
            c    = ($urandom_range(0, 19) == 0);
            ordy = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            cycle(en, c, $urandom, ordy);
            n_checks++;
            if ({bus.out_valid, bus.in_ready, bus.byte_cnt, bus.overflow} !== exp_status())
                $display("FAIL rand_status cyc=%0d act=%b exp=%b", i,
                         {bus.out_valid, bus.in_ready, bus.byte_cnt, bus.overflow},
                         exp_status());
            else n_pass++;
            n_checks++;
            if ({bus.doutD, bus.doutC, bus.doutB, bus.doutA} !== exp_dout())
                $display("FAIL rand_dout cyc=%0d act=%h exp=%h", i,
                         {bus.doutD, bus.doutC, bus.doutB, bus.doutA}, exp_dout());
            else n_pass++;
        end
    endtask

    initial begin
        bus.en_in     = 1'b0;
        bus.clr       = 1'b0;
        bus.dinA      = '0;
        bus.dinB      = '0;
        bus.dinC      = '0;
        bus.dinD      = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        model_reset();
        test_reset();
        test_basic_pack();
        test_backpressure();
        test_simul_push_pop();
        test_clr();
        test_gapped();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "bench timed out");
    end

endmodule
